// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding select encodings,
// default mult/div latencies, busy-counter states and stage-match helpers.
package hazard_pkg;

    typedef logic [1:0] fwd_t;

    localparam fwd_t FWD_RF = 2'b00;
    localparam fwd_t FWD_M  = 2'b01;
    localparam fwd_t FWD_W  = 2'b10;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    // Write-back view of a pipeline stage.
    typedef struct packed {
        logic       we;
        logic [4:0] wa;
    } wb_t;

    // Register 0 is hardwired, so a write to it never produces a hazard.
    function automatic logic reg_hit(input wb_t s, input logic [4:0] r);
        return s.we && (s.wa != 5'd0) && (s.wa == r);
    endfunction

    // A load in M has no data yet, so it cannot forward and W is tried next.
    function automatic fwd_t fwd_sel(input wb_t m, input logic ld_m, input wb_t w,
                                     input logic [4:0] r);
        if (reg_hit(m, r) && !ld_m)
            return FWD_M;
        else if (reg_hit(w, r))
            return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy tracker: loads the unit latency on start and counts
// down; busy is high while the remaining count is nonzero.
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic isDiv,
    output logic busy
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    md_state_e     state, state_nxt;
    logic [CW-1:0] count, count_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // A new start always wins, even mid-operation.
    always_comb begin
        count_nxt = count;
        if (start)
            count_nxt = isDiv ? CW'(DIV_LAT) : CW'(MULT_LAT);
        else if (state == MD_BUSY && count != '0)
            count_nxt = count - CW'(1);
        state_nxt = (count_nxt != '0) ? MD_BUSY : MD_IDLE;
    end

    always_comb begin
        busy = (state == MD_BUSY);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use, compare and mult/div stalls plus D/E forwarding.
// Define HAZARD_PERF_EN to add the perfStalls stall-cycle counter output.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic        useRsD,
    input  logic        useRtD,
    input  logic        cmpD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  waE,
    input  logic [4:0]  waM,
    input  logic [4:0]  waW,
    input  logic        weE,
    input  logic        weM,
    input  logic        weW,
    input  logic        ldE,
    input  logic        ldM,
    input  logic        mdStartE,
    input  logic        mdDivE,
    input  logic        mdUseD,
    output logic        stallF,
    output logic        stallD,
    output logic        Eclr,
    output logic [1:0]  fwdRsD,
    output logic [1:0]  fwdRtD,
    output logic [1:0]  fwdRsE,
    output logic [1:0]  fwdRtE,
    output logic        mdBusy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perfStalls
`endif
);

    wb_t  stE, stM, stW;
    logic hitE, hitM;
    logic ldStall, cmpStall, mdStall, stall;

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mdStartE),
        .isDiv (mdDivE),
        .busy  (mdBusy)
    );

    always_comb begin
        stE = '{we: weE, wa: waE};
        stM = '{we: weM, wa: waM};
        stW = '{we: weW, wa: waW};

        hitE = (useRsD && reg_hit(stE, rsD)) || (useRtD && reg_hit(stE, rtD));
        hitM = (useRsD && reg_hit(stM, rsD)) || (useRtD && reg_hit(stM, rtD));

        ldStall  = ldE && hitE;
        cmpStall = cmpD && (hitE || (ldM && hitM));
        mdStall  = mdUseD && (mdBusy || mdStartE);
        // Outputs are held quiet while reset is asserted.
        stall    = rst_n && (ldStall || cmpStall || mdStall);

        stallF = stall;
        stallD = stall;
        Eclr   = stall;

        fwdRsE = rst_n ? fwd_sel(stM, ldM, stW, rsE) : FWD_RF;
        fwdRtE = rst_n ? fwd_sel(stM, ldM, stW, rtE) : FWD_RF;
        fwdRsD = rst_n ? fwd_sel(stM, ldM, stW, rsD) : FWD_RF;
        fwdRtD = rst_n ? fwd_sel(stM, ldM, stW, rtD) : FWD_RF;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perfStalls <= '0;
        else if (stallD)
            perfStalls <= perfStalls + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural hazard model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rsD, rtD, rsE, rtE, waE, waM, waW;
    logic        useRsD, useRtD, cmpD, weE, weM, weW, ldE, ldM;
    logic        mdStartE, mdDivE, mdUseD;
    logic        stallF, stallD, Eclr, mdBusy;
    logic [1:0]  fwdRsD, fwdRtD, fwdRsE, fwdRtE;
`ifdef HAZARD_PERF_EN
    logic [31:0] perfStalls;
    int          perf;
`endif

    int errors = 0;
    int checks = 0;
    int md_left;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD), .cmpD(cmpD),
        .rsE(rsE), .rtE(rtE), .waE(waE), .waM(waM), .waW(waW),
        .weE(weE), .weM(weM), .weW(weW), .ldE(ldE), .ldM(ldM),
        .mdStartE(mdStartE), .mdDivE(mdDivE), .mdUseD(mdUseD),
        .stallF(stallF), .stallD(stallD), .Eclr(Eclr),
        .fwdRsD(fwdRsD), .fwdRtD(fwdRtD), .fwdRsE(fwdRsE), .fwdRtE(fwdRtE),
        .mdBusy(mdBusy)
`ifdef HAZARD_PERF_EN
        , .perfStalls(perfStalls)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a stall is needed if any used D source is pending in a way the pipe can't cover.
    function automatic logic exp_stall();
        logic hE = 1'b0, hM = 1'b0;
        for (int k = 0; k < 2; k++) begin
            logic [4:0] r = (k == 0) ? rsD : rtD;
            logic       u = (k == 0) ? useRsD : useRtD;
            if (u && r != 5'd0) begin
                if (weE && waE == r) hE = 1'b1;
                if (weM && waM == r) hM = 1'b1;
            end
        end
        if (!rst_n) return 1'b0;
        return (ldE && hE) || (cmpD && (hE || (ldM && hM))) ||
               (mdUseD && (md_left > 0 || mdStartE));
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] r);
        if (!rst_n || r == 5'd0) return 2'd0;
        if (weM && waM == r && !ldM) return 2'd1;
        if (weW && waW == r) return 2'd2;
        return 2'd0;
    endfunction

    task automatic set_rst(input logic v);
        rst_n = v;
        if (!v) begin
            md_left = 0;
`ifdef HAZARD_PERF_EN
            perf = 0;
`endif
        end
    endtask

    task automatic clear();
        {rsD, rtD, rsE, rtE, waE, waM, waW} = '0;
        {useRsD, useRtD, cmpD, weE, weM, weW, ldE, ldM} = '0;
        {mdStartE, mdDivE, mdUseD} = '0;
    endtask

    // One clock: compare everything against the model, then advance the model.
    task automatic tick();
        logic s;
        @(negedge clk);
        s = exp_stall();
        chk("m_stallF", 32'(stallF), 32'(s));
        chk("m_stallD", 32'(stallD), 32'(s));
        chk("m_Eclr",   32'(Eclr),   32'(s));
        chk("m_fwdRsD", 32'(fwdRsD), 32'(exp_fwd(rsD)));
        chk("m_fwdRtD", 32'(fwdRtD), 32'(exp_fwd(rtD)));
        chk("m_fwdRsE", 32'(fwdRsE), 32'(exp_fwd(rsE)));
        chk("m_fwdRtE", 32'(fwdRtE), 32'(exp_fwd(rtE)));
        chk("m_mdBusy", 32'(mdBusy), 32'(md_left != 0));
`ifdef HAZARD_PERF_EN
        chk("m_perf", perfStalls, 32'(perf));
`endif
        @(posedge clk);
        if (rst_n) begin
`ifdef HAZARD_PERF_EN
            if (s) perf++;
`endif
            if (mdStartE) md_left = mdDivE ? 10 : 5;
            else if (md_left > 0) md_left--;
        end
        #1;
    endtask

    initial begin
        int n;
        clear();
        set_rst(1'b0);
        // Hazardous inputs during reset must still give quiet outputs.
        ldE = 1; weE = 1; waE = 8; rsD = 8; useRsD = 1;
        weM = 1; waM = 9; rsE = 9; mdStartE = 1; mdUseD = 1;
        #2;
        chk("rst_stallD", 32'(stallD), 0);
        chk("rst_Eclr", 32'(Eclr), 0);
        chk("rst_fwdRsE", 32'(fwdRsE), 0);
        chk("rst_mdBusy", 32'(mdBusy), 0);
        tick(); tick();
        clear();
        set_rst(1'b1);
        tick();

        // Load-use stall, then waE=0 removes it
        ldE = 1; weE = 1; waE = 8; rsD = 8; useRsD = 1; #1;
        chk("lu_stallF", 32'(stallF), 1);
        chk("lu_stallD", 32'(stallD), 1);
        chk("lu_Eclr", 32'(Eclr), 1);
        tick();
        waE = 0; #1;
        chk("lu_r0_stallD", 32'(stallD), 0);
        tick();
        waE = 8; useRsD = 0; #1;
        chk("lu_unused_stallD", 32'(stallD), 0);
        tick();

        // E forwarding priority M over W, and a load in M yields to W
        clear();
        weM = 1; waM = 9; weW = 1; waW = 9; rsE = 9; rtE = 9; #1;
        chk("fw_M_rsE", 32'(fwdRsE), 1);
        tick();
        weM = 0; #1;
        chk("fw_W_rsE", 32'(fwdRsE), 2);
        tick();
        weM = 1; ldM = 1; #1;
        chk("fw_ldM_rtE", 32'(fwdRtE), 2);
        tick();
        weW = 0; #1;
        chk("fw_none_rtE", 32'(fwdRtE), 0);
        tick();
        clear(); weM = 1; waM = 0; weW = 1; waW = 0; #1;
        chk("fw_r0_rsE", 32'(fwdRsE), 0);
        tick();

        // Branch compare stall, then M forward when the producer moves on
        clear();
        cmpD = 1; rtD = 5; useRtD = 1; weE = 1; waE = 5; #1;
        chk("cmp_E_stallD", 32'(stallD), 1);
        tick();
        weE = 0; waE = 0; weM = 1; waM = 5; ldM = 0; #1;
        chk("cmp_M_stallD", 32'(stallD), 0);
        chk("cmp_M_fwdRtD", 32'(fwdRtD), 1);
        tick();
        ldM = 1; #1;
        chk("cmp_ldM_stallD", 32'(stallD), 1);
        chk("cmp_ldM_fwdRtD", 32'(fwdRtD), 0);
        tick();

        // Divide: start cycle plus exactly 10 busy cycles of stall
        clear();
        mdStartE = 1; mdDivE = 1; mdUseD = 1; #1;
        chk("div_start_stall", 32'(stallD), 1);
        chk("div_start_busy", 32'(mdBusy), 0);
        tick();
        mdStartE = 0; #1;
        for (int i = 0; i < 10; i++) begin
            chk("div_busy", 32'(mdBusy), 1);
            chk("div_stall", 32'(stallD), 1);
            tick();
        end
        chk("div_done_busy", 32'(mdBusy), 0);
        chk("div_done_stall", 32'(stallD), 0);
        tick();

        // Restart during a multiply reloads with the divide latency
        clear();
        mdStartE = 1; tick();
        mdStartE = 0; tick(); tick();
        mdStartE = 1; mdDivE = 1; tick();
        mdStartE = 0;
        n = 0;
        while (mdBusy && n < 20) begin
            n++;
            tick();
        end
        chk("restart_busy_cycles", n, 10);

        // Reset in the middle of a multiply abandons it
        clear();
        mdStartE = 1; mdUseD = 1; tick();
        mdStartE = 0; tick(); tick();
        set_rst(1'b0); #1;
        chk("mdrst_busy", 32'(mdBusy), 0);
        chk("mdrst_stallF", 32'(stallF), 0);
        tick();
        set_rst(1'b1); #1;
        chk("mdrel_busy", 32'(mdBusy), 0);
        chk("mdrel_stallD", 32'(stallD), 0);
        tick();
        chk("mdrel_busy2", 32'(mdBusy), 0);

`ifdef HAZARD_PERF_EN
        // 3 load-use stalls + mult start and 5 busy cycles with mdUseD = 9
        chk("perf_cleared", perfStalls, 0);
        clear();
        ldE = 1; weE = 1; waE = 8; rsD = 8; useRsD = 1;
        tick(); tick(); tick();
        clear();
        mdStartE = 1; mdUseD = 1; tick();
        mdStartE = 0;
        for (int i = 0; i < 5; i++) tick();
        mdUseD = 0; tick();
        chk("perf_total", perfStalls, 9);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
